fetch_ctrl: RTL and testbench

- Fetch sequencer that owns the program counter and drives a single-outstanding instruction-memory request/ack port.
- Hands fetched instructions to decode over a valid/ready handshake.
- Applies branch redirects (branch & zero) by discarding any in-flight or buffered fetch.
- Sits between instruction memory and decode in the pipelined core.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_perf_counters.sv | 29 ++
 rtl/fetch_ctrl.sv | 125 ++++++++++++
 tb/tb_fetch_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer.
//   fetch_state_t        : IDLE / REQ / VALID fetch FSM states
//   XLEN_DEFAULT         : default address/data width
//   RESET_VECTOR_DEFAULT : default PC after reset
//   PC_STEP              : byte increment between sequential instructions
//   ALIGN_MASK           : low address bits forced to zero on redirect
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

    localparam int          XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int          PC_STEP              = 4;
    localparam int          ALIGN_MASK           = 3;

endpackage

// File: rtl/fetch_perf_counters.sv
// fetch_perf_counters: saturating event counters for the fetch sequencer.
// Only instantiated when FETCH_PERF_EN is defined.
// Ports:
//   clk, rst     : clock, async active-low reset
//   fetch_evt    : an instruction was handed to decode this cycle
//   stall_evt    : fetch was stalled this cycle (decode or imem waiting)
//   fetch_count  : saturating count of fetch_evt
//   stall_count  : saturating count of stall_evt
module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_evt,
    input  logic        stall_evt,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            // Counters stick at all-ones rather than wrapping.
            if (fetch_evt && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
            if (stall_evt && stall_count != '1) stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer. Owns the PC, issues one outstanding
// instruction-memory request at a time, buffers the returned word for
// decode behind a valid/ready handshake, and applies branch redirects.
// Optional macro FETCH_PERF_EN adds fetch_count / stall_count outputs.
// Ports:
//   clk, rst                 : clock, async active-low reset
//   branch, zero             : redirect when both are high
//   branch_dest              : redirect target (low two bits ignored)
//   imem_req, imem_addr      : fetch request, held until imem_ack
//   imem_ack, imem_rdata     : single-cycle response strobe + data
//   inst_valid, inst, inst_pc: buffered instruction to decode
//   inst_ready               : decode accepts inst
//   pc                       : architectural fetch PC
//   fetch_count, stall_count : perf counters (FETCH_PERF_EN only)
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch,
    input  logic            zero,
    input  logic [XLEN-1:0] branch_dest,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic [XLEN-1:0] pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);

    fetch_state_t    state;
    logic            discard;
    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_inc;

    assign redirect = branch & zero & (state != IDLE);
    assign target   = branch_dest & ~XLEN'(ALIGN_MASK);
    assign pc_inc   = pc + XLEN'(PC_STEP);   // wraps silently at 2^XLEN

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_VECTOR;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= RESET_VECTOR;
            discard    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Late acks from before reset land here and are ignored.
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                REQ: begin
                    if (imem_ack) begin
                        if (discard || redirect) begin
                            // Stale response: drop it and reissue at the
                            // (possibly just redirected) PC. imem_req stays
                            // high; the old request retired with this ack.
                            discard   <= 1'b0;
                            imem_addr <= redirect ? target : pc;
                            if (redirect) pc <= target;
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= imem_addr;
                            inst_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= VALID;
                        end
                    end else if (redirect) begin
                        // Request cannot be aborted; remember to drop its data.
                        discard <= 1'b1;
                        pc      <= target;
                    end
                end
                VALID: begin
                    // A same-cycle handshake still consumes inst; the
                    // redirect only overrides the next PC.
                    if (redirect) begin
                        pc         <= target;
                        imem_addr  <= target;
                        imem_req   <= 1'b1;
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end else if (inst_ready) begin
                        pc         <= pc_inc;
                        imem_addr  <= pc_inc;
                        imem_req   <= 1'b1;
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_counters u_perf (
        .clk         (clk),
        .rst         (rst),
        .fetch_evt   (inst_valid & inst_ready),
        .stall_evt   ((inst_valid & ~inst_ready) | (imem_req & ~imem_ack)),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch, zero;
    logic [31:0] branch_dest;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .branch      (branch),
        .zero        (zero),
        .branch_dest (branch_dest),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .pc          (pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a pending request for lat cycles, then ack with data.
    // Leaves the bench one cycle after the ack edge.
    task automatic serve(input int lat, input logic [31:0] addr, input logic [31:0] data);
        for (int i = 0; i < lat; i++) begin
            chk("req_wait", {31'd0, imem_req}, 32'd1);
            chk("addr_wait", imem_addr, addr);
            tick();
        end
        chk("addr_ack", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic redir(input logic [31:0] dest);
        branch = 1'b1; zero = 1'b1; branch_dest = dest;
    endtask

    task automatic no_redir();
        branch = 1'b0; zero = 1'b0; branch_dest = '0;
    endtask

    task automatic chk_valid(input string tag, input logic [31:0] w, input logic [31:0] a);
        chk({tag, "_vld"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, "_inst"}, inst, w);
        chk({tag, "_ipc"}, inst_pc, a);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; no_redir();
        imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ipc", inst_pc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_vld", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);

        rst = 1'b1;
        tick();                             // IDLE -> REQ
        chk("first_req", {31'd0, imem_req}, 32'd1);

        // Fetch 0x0; decode stalls 5 cycles
        serve(1, 32'h0, 32'h0050_0093);
        chk_valid("f0", 32'h0050_0093, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_valid("stall", 32'h0050_0093, 32'h0);
            chk("stall_pc", pc, 32'h0);
        end
        inst_ready = 1'b1;
        tick();
        chk("rel_pc", pc, 32'h4);
        chk("rel_addr", imem_addr, 32'h4);
        chk("rel_vld", {31'd0, inst_valid}, 32'd0);

        // Fetch 0x4, then request for 0x8
        serve(1, 32'h4, 32'h0010_0113);
        chk_valid("f4", 32'h0010_0113, 32'h4);
        tick();
        chk("seq_addr8", imem_addr, 32'h8);
        chk("seq_req8", {31'd0, imem_req}, 32'd1);

        // Two redirects while 0x8 is outstanding; latest wins
        redir(32'h0000_01F0);
        tick();
        chk("rd1_pc", pc, 32'h1F0);
        chk("rd1_addr", imem_addr, 32'h8);
        redir(32'h0000_0100);
        tick();
        no_redir();
        chk("rd2_pc", pc, 32'h100);
        chk("rd2_addr", imem_addr, 32'h8);
        tick();
        chk("rd_hold_addr", imem_addr, 32'h8);
        chk("rd_hold_req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        chk("drop_vld", {31'd0, inst_valid}, 32'd0);
        chk("drop_req", {31'd0, imem_req}, 32'd1);
        chk("drop_addr", imem_addr, 32'h100);

        // branch without zero is not a redirect
        branch = 1'b1; zero = 1'b0; branch_dest = 32'h40;
        tick();
        no_redir();
        chk("nz_pc", pc, 32'h100);
        serve(0, 32'h100, 32'h00A0_0513);
        chk_valid("f100", 32'h00A0_0513, 32'h100);

        // Redirect in VALID with same-cycle handshake; target 0x203 aligned
        redir(32'h0000_0203);
        tick();
        no_redir();
        chk("vrd_vld", {31'd0, inst_valid}, 32'd0);
        chk("vrd_pc", pc, 32'h200);
        chk("vrd_addr", imem_addr, 32'h200);
        chk("vrd_req", {31'd0, imem_req}, 32'd1);

        // Redirect coincident with ack: data dropped, refetch at target
        tick();
        redir(32'hFFFF_FFFE);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        no_redir();
        imem_ack = 1'b0; imem_rdata = '0;
        chk("ackrd_vld", {31'd0, inst_valid}, 32'd0);
        chk("ackrd_addr", imem_addr, 32'hFFFF_FFFC);
        chk("ackrd_pc", pc, 32'hFFFF_FFFC);

        // PC wrap
        serve(1, 32'hFFFF_FFFC, 32'h0000_0013);
        chk_valid("fwrap", 32'h0000_0013, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Async reset mid-request, then a late ack during IDLE
        serve(1, 32'h0, 32'h0000_0013);
        tick();
        chk("pre_rst_pc", pc, 32'h4);
        tick();
        #3;
        rst = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_vld", {31'd0, inst_valid}, 32'd0);
        chk("arst_inst", inst, 32'h0);
        tick();
        rst = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        inst_ready = 1'b0;
        tick();
        imem_ack = 1'b0; imem_rdata = '0;
        chk("late_ack_vld", {31'd0, inst_valid}, 32'd0);
        chk("late_ack_req", {31'd0, imem_req}, 32'd1);
        chk("late_ack_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        chk("perf_rst_fetch", fetch_count, 32'd0);
        chk("perf_rst_stall", stall_count, 32'd0);
`endif

        // 4 accepted fetches, 3 ready-low cycles, 1-cycle ack each
        serve(1, 32'h0, 32'h0000_0093);
        chk_valid("p0", 32'h0000_0093, 32'h0);
        tick(); tick(); tick();
        inst_ready = 1'b1;
        tick();
        for (int i = 1; i < 4; i++) begin
            serve(1, 32'(i * 4), 32'h100 + 32'(i));
            chk_valid("pn", 32'h100 + 32'(i), 32'(i * 4));
            tick();
        end
        chk("perf_pc", pc, 32'h10);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", fetch_count, 32'd4);
        chk("perf_stall", stall_count, 32'd7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
